// File: rtl/cv32e40x_irq_arbiter.sv
// Basic-mode interrupt front end: synchronizes irq_i, keeps mip (level and sticky
// edge lines), picks the highest-priority enabled interrupt and gates the request.
module cv32e40x_irq_arbiter #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] IRQ_MASK    = 32'hFFFF_0888,
    parameter logic [31:0] EDGE_MASK   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] irq_i,
    input  logic [31:0] mie_i,
    input  logic        mstatus_mie_i,
    input  logic        debug_mode_i,
    input  logic        dcsr_step_i,
    input  logic        dcsr_stepie_i,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_id_ack_i,
    output logic        irq_req_ctrl_o,
    output logic [9:0]  irq_id_ctrl_o,
    output logic        irq_wu_ctrl_o,
    output logic [31:0] mip_o
);

    logic [31:0] s;
    logic [31:0] mip_q;
    logic [31:0] mip_d;
    logic [31:0] en;
    logic [4:0]  win_id;
    logic        any_en;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = irq_i;
        end else begin : g_sync
            logic [31:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    sync_q[0] <= irq_i;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_line
            if (EDGE_MASK[gi]) begin : g_edge
                logic prev_q;
                logic clr;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        prev_q <= 1'b0;
                    end else begin
                        prev_q <= s[gi];
                    end
                end

                assign clr = irq_ack_i && (irq_id_ack_i == 5'(gi));
                // A rising edge in the ack cycle wins over the clear.
                assign mip_d[gi] = IRQ_MASK[gi] & ((s[gi] & ~prev_q) | (mip_q[gi] & ~clr));
            end else begin : g_level
                assign mip_d[gi] = s[gi] & IRQ_MASK[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mip_q <= '0;
        end else begin
            mip_q <= mip_d;
        end
    end

    assign en     = mip_q & mie_i & IRQ_MASK;
    assign any_en = |en;

    // Evaluated lowest priority first so later matches override: 7, 3, 11, 16..31.
    always_comb begin
        win_id = 5'd0;
        if (en[7])  win_id = 5'd7;
        if (en[3])  win_id = 5'd3;
        if (en[11]) win_id = 5'd11;
        for (int k = 16; k < 32; k++) begin
            if (en[k]) win_id = 5'(k);
        end
    end

    assign irq_req_ctrl_o = any_en & mstatus_mie_i & ~debug_mode_i & ~(dcsr_step_i & ~dcsr_stepie_i);
    assign irq_wu_ctrl_o  = any_en & ~debug_mode_i;
    assign irq_id_ctrl_o  = {5'd0, win_id};
    assign mip_o          = mip_q;

endmodule

// File: tb/tb_cv32e40x_irq_arbiter.sv
// Directed bench for cv32e40x_irq_arbiter: vector table for level/priority/gating,
// hand sequences for latency, edge-line ack behaviour and reset.
module tb_cv32e40x_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] irq_i;
    logic [31:0] mie_i;
    logic        mstatus_mie_i;
    logic        debug_mode_i;
    logic        dcsr_step_i;
    logic        dcsr_stepie_i;
    logic        irq_ack_i;
    logic [4:0]  irq_id_ack_i;
    logic        irq_req_ctrl_o;
    logic [9:0]  irq_id_ctrl_o;
    logic        irq_wu_ctrl_o;
    logic [31:0] mip_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cv32e40x_irq_arbiter #(
        .SYNC_STAGES(2),
        .IRQ_MASK   (32'hFFFF_0888),
        .EDGE_MASK  (32'h0001_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_i         (irq_i),
        .mie_i         (mie_i),
        .mstatus_mie_i (mstatus_mie_i),
        .debug_mode_i  (debug_mode_i),
        .dcsr_step_i   (dcsr_step_i),
        .dcsr_stepie_i (dcsr_stepie_i),
        .irq_ack_i     (irq_ack_i),
        .irq_id_ack_i  (irq_id_ack_i),
        .irq_req_ctrl_o(irq_req_ctrl_o),
        .irq_id_ctrl_o (irq_id_ctrl_o),
        .irq_wu_ctrl_o (irq_wu_ctrl_o),
        .mip_o         (mip_o)
    );

    typedef struct {
        string       name;
        logic [31:0] irq;
        logic [31:0] mie;
        logic        gmie;
        logic        dbg;
        logic        step;
        logic        stepie;
        logic        ack;
        logic [4:0]  ack_id;
        logic        exp_req;
        logic [9:0]  exp_id;
        logic        exp_wu;
        logic [31:0] exp_mip;
    } vec_t;

    vec_t vecs [13];

    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic req, input logic [9:0] id,
                             input logic wu, input logic [31:0] mip);
        check({name, ".req"}, {31'd0, irq_req_ctrl_o}, {31'd0, req});
        check({name, ".id"},  {22'd0, irq_id_ctrl_o},  {22'd0, id});
        check({name, ".wu"},  {31'd0, irq_wu_ctrl_o},  {31'd0, wu});
        check({name, ".mip"}, mip_o, mip);
        $display("txn %-10s irq=%08h mie=%08h -> req=%0b id=%0d wu=%0b mip=%08h",
                 name, irq_i, mie_i, irq_req_ctrl_o, irq_id_ctrl_o, irq_wu_ctrl_o, mip_o);
    endtask

    initial begin
        //          name         irq           mie           g  d  s  si a  aid  req id  wu mip
        vecs[0]  = '{"prio20",  32'h0012_0888, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0,  1, 20, 1, 32'h0012_0888};
        vecs[1]  = '{"prio11",  32'h0000_0888, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0,  1, 11, 1, 32'h0000_0888};
        vecs[2]  = '{"prio3",   32'h0000_0088, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0,  1, 3,  1, 32'h0000_0088};
        vecs[3]  = '{"prio7",   32'h0000_0080, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0,  1, 7,  1, 32'h0000_0080};
        vecs[4]  = '{"mie7",    32'h0000_0888, 32'h0000_0080, 1, 0, 0, 0, 0, 0,  1, 7,  1, 32'h0000_0888};
        vecs[5]  = '{"gmie0",   32'h0000_0888, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0,  0, 11, 1, 32'h0000_0888};
        vecs[6]  = '{"debug",   32'h0000_0888, 32'hFFFF_FFFF, 1, 1, 0, 0, 0, 0,  0, 11, 0, 32'h0000_0888};
        vecs[7]  = '{"step",    32'h0000_0888, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0,  0, 11, 1, 32'h0000_0888};
        vecs[8]  = '{"stepie",  32'h0000_0888, 32'hFFFF_FFFF, 1, 0, 1, 1, 0, 0,  1, 11, 1, 32'h0000_0888};
        vecs[9]  = '{"unimpl5", 32'h0000_0020, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0,  0, 0,  0, 32'h0000_0000};
        vecs[10] = '{"ack_lvl", 32'h0000_0800, 32'hFFFF_FFFF, 1, 0, 0, 0, 1, 11, 1, 11, 1, 32'h0000_0800};
        vecs[11] = '{"prio31",  32'h8000_0800, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0,  1, 31, 1, 32'h8000_0800};
        vecs[12] = '{"idle",    32'h0000_0000, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0,  0, 0,  0, 32'h0000_0000};

        rst_n = 1'b0;
        irq_i = 32'hFFFF_FFFF;
        mie_i = '0;
        mstatus_mie_i = 1'b0;
        debug_mode_i = 1'b0;
        dcsr_step_i = 1'b0;
        dcsr_stepie_i = 1'b0;
        irq_ack_i = 1'b0;
        irq_id_ack_i = '0;

        // Reset with all lines high; synchronizer restarts from 0, so all implemented lines appear.
        for (int c = 0; c < 3; c++) begin
            tick(1);
            check_all("in_reset", 0, 0, 0, 32'h0);
        end
        rst_n = 1'b1;
        tick(2);
        check("rel+2.mip", mip_o, 32'h0);
        tick(1);
        check_all("rel+3", 0, 0, 0, 32'hFFFF_0888);

        // Clear: level lines fall, sticky edge line 16 needs an ack.
        irq_i = '0;
        tick(3);
        check("sticky16", mip_o, 32'h0001_0000);
        irq_ack_i = 1'b1;
        irq_id_ack_i = 5'd16;
        tick(1);
        irq_ack_i = 1'b0;
        check("clr16", mip_o, 32'h0);

        // Latency: request visible after exactly 3 edges, and falls 3 edges after drop.
        mie_i = 32'h0000_0800;
        mstatus_mie_i = 1'b1;
        irq_i = 32'h0000_0800;
        tick(2);
        check("lat2.req", {31'd0, irq_req_ctrl_o}, 32'd0);
        tick(1);
        check_all("lat3", 1, 11, 1, 32'h0000_0800);
        irq_i = '0;
        tick(2);
        check("drop2.req", {31'd0, irq_req_ctrl_o}, 32'd1);
        tick(1);
        check_all("drop3", 0, 0, 0, 32'h0);

        for (int v = 0; v < 13; v++) begin
            irq_i = vecs[v].irq;
            mie_i = vecs[v].mie;
            mstatus_mie_i = vecs[v].gmie;
            debug_mode_i = vecs[v].dbg;
            dcsr_step_i = vecs[v].step;
            dcsr_stepie_i = vecs[v].stepie;
            irq_ack_i = vecs[v].ack;
            irq_id_ack_i = vecs[v].ack_id;
            tick(3);
            check_all(vecs[v].name, vecs[v].exp_req, vecs[v].exp_id, vecs[v].exp_wu, vecs[v].exp_mip);
        end
        irq_ack_i = 1'b0;

        // Edge line 16: one-cycle pulse becomes sticky.
        mie_i = 32'h0001_0000;
        irq_i = 32'h0001_0000;
        tick(1);
        irq_i = '0;
        tick(2);
        check_all("edge_set", 1, 16, 1, 32'h0001_0000);
        tick(5);
        check_all("edge_hold", 1, 16, 1, 32'h0001_0000);

        // Ack for a different ID must not clear line 16.
        irq_ack_i = 1'b1;
        irq_id_ack_i = 5'd17;
        tick(1);
        irq_ack_i = 1'b0;
        check("ack17", mip_o, 32'h0001_0000);

        irq_ack_i = 1'b1;
        irq_id_ack_i = 5'd16;
        tick(1);
        irq_ack_i = 1'b0;
        check_all("edge_ack", 0, 0, 0, 32'h0);

        // New edge landing in the ack cycle: set wins.
        irq_i = 32'h0001_0000;
        tick(1);
        check("pre_set", mip_o, 32'h0);
        irq_i = '0;
        tick(1);
        irq_ack_i = 1'b1;
        irq_id_ack_i = 5'd16;
        tick(1);
        irq_ack_i = 1'b0;
        check("set_wins", mip_o, 32'h0001_0000);
        tick(1);
        check("set_wins+1", mip_o, 32'h0001_0000);

        // Higher-priority level line overrides pending edge line 16.
        mie_i = 32'hFFFF_FFFF;
        irq_i = 32'h0002_0000;
        tick(3);
        check_all("prio17", 1, 17, 1, 32'h0003_0000);
        irq_i = '0;
        tick(3);
        check("back16", {22'd0, irq_id_ctrl_o}, 32'd16);

        // Mid-operation reset drops the pending edge interrupt.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check_all("rst_drop", 0, 0, 0, 32'h0);
        tick(4);
        check("post_rst", mip_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
